// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and the cyclic priority search for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned MAXREQ = 8;
    localparam int unsigned RIW    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic           found;
        logic [RIW-1:0] idx;
    } rr_res_t;

    // First set, non-excluded bit of req searching upward from start, wrapping at n.
    function automatic rr_res_t rr_pick(input logic [MAXREQ-1:0] req,
                                        input logic [RIW-1:0]    start,
                                        input logic [MAXREQ-1:0] excl,
                                        input int unsigned       n);
        rr_res_t     r;
        int unsigned i;
        r = '0;
        for (int unsigned k = 0; k < MAXREQ; k++) begin
            i = 32'(start) + k;
            if (i >= n) i = i - n;
            if ((k < n) && !r.found && req[i[RIW-1:0]] && !excl[i[RIW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = i[RIW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
interface fifo_wr_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               Ffull;
    logic               Wen;
    logic [DW-1:0]      Din;

    modport master (output req, din, Ffull, input gnt, ack, Wen, Din);
    modport slave  (input req, din, Ffull, output gnt, ack, Wen, Din);
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational cyclic priority encoder: req, start index and exclude mask in, one-hot winner out.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    input  logic [NREQ-1:0] excl_i,
    output logic [NREQ-1:0] win_oh_c_o,
    output logic [IW-1:0]   win_idx_c_o,
    output logic            win_vld_c_o
);

    rr_res_t res_c;

    always_comb begin
        res_c       = rr_pick(MAXREQ'(req_i), RIW'(start_i), MAXREQ'(excl_i), NREQ);
        win_vld_c_o = res_c.found;
        win_idx_c_o = IW'(res_c.idx);
        win_oh_c_o  = res_c.found ? (NREQ'(1) << res_c.idx) : '0;
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst round-robin arbiter sharing one FIFO write port between NREQ producers.
// Optional stall counter built when FIFO_ARB_STALL_CNT_EN is defined.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAXBURST = 4,
    parameter int unsigned DW       = DW_DEF
) (
    input  logic ck,
    input  logic rst,
    fifo_wr_arb_if.slave bus
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    input  logic        stall_clr,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAXBURST) + 1;

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   beat_cnt_q;

    logic [NREQ-1:0] ack_c;
    logic            own_req_c;
    logic            beat_acc_c;
    logic [CW-1:0]   cnt_inc_c;
    logic            cap_c;
    logic            release_c;
    logic [IW-1:0]   base_c;
    logic [IW-1:0]   start_c;
    logic [NREQ-1:0] excl_c;
    logic [DW-1:0]   din_mux_c;
    logic [NREQ-1:0] win_oh_c;
    logic [IW-1:0]   win_idx_c;
    logic            win_vld_c;

    // Handshake, burst-cap and release decode for the current owner.
    always_comb begin
        ack_c      = gnt_q & bus.req & {NREQ{~bus.Ffull}};
        own_req_c  = |(gnt_q & bus.req);
        beat_acc_c = |ack_c;
        cnt_inc_c  = beat_cnt_q + CW'(1);
        cap_c      = (state_q == GRANT) && beat_acc_c && (cnt_inc_c == CW'(MAXBURST));
        release_c  = (state_q == GRANT) && (!own_req_c || cap_c);
        base_c     = (state_q == IDLE) ? last_q : owner_q;
        start_c    = (base_c == IW'(NREQ - 1)) ? '0 : base_c + IW'(1);
        excl_c     = cap_c ? gnt_q : '0;
    end

    always_comb begin
        din_mux_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) din_mux_c = din_mux_c | bus.din[i*DW +: DW];
        end
    end

    fifo_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i       (bus.req),
        .start_i     (start_c),
        .excl_i      (excl_c),
        .win_oh_c_o  (win_oh_c),
        .win_idx_c_o (win_idx_c),
        .win_vld_c_o (win_vld_c)
    );

    // A capped owner that is the only requester falls through to a fresh burst.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            last_q     <= IW'(NREQ - 1);
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld_c) begin
                        state_q    <= GRANT;
                        gnt_q      <= win_oh_c;
                        owner_q    <= win_idx_c;
                        beat_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        last_q     <= owner_q;
                        beat_cnt_q <= '0;
                        if (win_vld_c) begin
                            gnt_q   <= win_oh_c;
                            owner_q <= win_idx_c;
                        end else if (!cap_c) begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (beat_acc_c) begin
                        beat_cnt_q <= cnt_inc_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt = gnt_q;
    assign bus.ack = ack_c;
    assign bus.Wen = beat_acc_c;
    assign bus.Din = din_mux_c;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Cycles the owner wants to write but the FIFO is full; saturating.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_clr) begin
            stall_cnt_q <= '0;
        end else if ((state_q == GRANT) && own_req_c && bus.Ffull && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: per-scenario tasks plus a write-data scoreboard.
module tb_fifo_wr_arb;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned MAXBURST = 4;

    logic ck = 1'b0;
    logic rst;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned n_wr   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic [16:0] e17;

    fifo_wr_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef FIFO_ARB_STALL_CNT_EN
    logic        stall_clr;
    logic [15:0] stall_cnt;
`endif

    fifo_wr_arb #(
        .NREQ     (NREQ),
        .MAXBURST (MAXBURST),
        .DW       (DW)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
`endif
    );

    always #10 ck = ~ck;

    function automatic logic [16:0] obs();
        return {bus.gnt, bus.ack, bus.Wen, bus.Din};
    endfunction

    task automatic cyc();
        @(negedge ck);
    endtask

    task automatic set_din(input int unsigned i, input logic [7:0] v);
        bus.din[i*DW +: DW] = v;
    endtask

    // Scoreboard: every FIFO write must match the next expected byte.
    always @(negedge ck) begin
        #5;
        if (bus.Wen === 1'b1) begin
            n_chk++;
            n_wr++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_data: unexpected write Din=%h, no write expected", bus.Din);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.Din !== mon_exp) begin
                    n_fail++;
                    $display("FAIL wr_data: Din=%h expected %h", bus.Din, mon_exp);
                end
            end
        end
    end

    task automatic apply_reset();
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        bus.req   = '1;
        bus.din   = '0;
        bus.Ffull = 1'b0;
`ifdef FIFO_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        repeat (2) cyc();
        #1;
        n_chk++;
        if (obs() !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected %h", obs(), 17'h0);
        end
        cyc();
        rst     = 1'b1;
        bus.req = '0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            #1;
            n_chk++;
            if (obs() !== 17'h0) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", k, obs(), 17'h0);
            end
        end
    endtask

    task automatic test_single();
        cyc();
        set_din(2, 8'hA5);
        bus.req = 4'b0100;
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_latency: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            exp_q.push_back(8'hA5);
            #1;
            e17 = {4'b0100, 4'b0100, 1'b1, 8'hA5};
            n_chk++;
            if (obs() !== e17) begin
                n_fail++;
                $display("FAIL single_beat[%0d]: got %h expected %h", k, obs(), e17);
            end
        end
        cyc();
        bus.req = 4'b0000;
        #1;
        n_chk++;
        if (bus.Wen !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop_wen: Wen=%b expected 0", bus.Wen);
        end
        cyc();
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
        // last is now 2, so requester 3 outranks requester 0
        cyc();
        set_din(3, 8'h3C);
        set_din(0, 8'h0F);
        bus.req = 4'b1001;
        cyc();
        exp_q.push_back(8'h3C);
        #1;
        n_chk++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL last_ptr: gnt=%b expected %b", bus.gnt, 4'b1000);
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL last_ptr_idle: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
    endtask

    task automatic test_round_robin();
        int unsigned w0;
        logic [3:0]  g;
        apply_reset();
        cyc();
        for (int unsigned i = 0; i < NREQ; i++) set_din(i, 8'(8'h10 + i));
        bus.req = 4'b1111;
        for (int b = 0; b < 20; b++) exp_q.push_back(8'(8'h10 + ((b / 4) % 4)));
        w0 = n_wr;
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_latency: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
        for (int b = 0; b < 20; b++) begin
            cyc();
            #1;
            g   = 4'(1 << ((b / 4) % 4));
            e17 = {g, g, 1'b1, 8'(8'h10 + ((b / 4) % 4))};
            n_chk++;
            if (obs() !== e17) begin
                n_fail++;
                $display("FAIL rr_beat[%0d]: got %h expected %h", b, obs(), e17);
            end
        end
        cyc();
        bus.req = 4'b0000;
        #1;
        n_chk++;
        if ((n_wr - w0) !== 20) begin
            n_fail++;
            $display("FAIL rr_write_count: writes=%0d expected 20", n_wr - w0);
        end
        cyc();
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_idle: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
    endtask

    task automatic test_full_stall();
        cyc();
        set_din(1, 8'hB0);
        bus.req = 4'b0010;
        cyc();
        exp_q.push_back(8'hB0);
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_grant: gnt=%b expected %b", bus.gnt, 4'b0010);
        end
        // requester 0 arrives mid-burst and must wait
        cyc();
        set_din(1, 8'hB1);
        set_din(0, 8'hC0);
        bus.req = 4'b0011;
        exp_q.push_back(8'hB1);
        #1;
        e17 = {4'b0010, 4'b0010, 1'b1, 8'hB1};
        n_chk++;
        if (obs() !== e17) begin
            n_fail++;
            $display("FAIL stall_beat2: got %h expected %h", obs(), e17);
        end
        for (int k = 0; k < 7; k++) begin
            cyc();
            bus.Ffull = 1'b1;
            set_din(1, 8'hB2);
            #1;
            e17 = {4'b0010, 4'b0000, 1'b0, 8'hB2};
            n_chk++;
            if (obs() !== e17) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", k, obs(), e17);
            end
        end
        cyc();
        bus.Ffull = 1'b0;
        exp_q.push_back(8'hB2);
        #1;
        e17 = {4'b0010, 4'b0010, 1'b1, 8'hB2};
        n_chk++;
        if (obs() !== e17) begin
            n_fail++;
            $display("FAIL stall_resume3: got %h expected %h", obs(), e17);
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_chk++;
        if (stall_cnt !== 16'd7) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d expected 7", stall_cnt);
        end
        stall_clr = 1'b1;
`endif
        cyc();
        set_din(1, 8'hB3);
        exp_q.push_back(8'hB3);
`ifdef FIFO_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        #1;
        e17 = {4'b0010, 4'b0010, 1'b1, 8'hB3};
        n_chk++;
        if (obs() !== e17) begin
            n_fail++;
            $display("FAIL stall_resume4: got %h expected %h", obs(), e17);
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_chk++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_clr: got %0d expected 0", stall_cnt);
        end
`endif
        cyc();
        exp_q.push_back(8'hC0);
        #1;
        e17 = {4'b0001, 4'b0001, 1'b1, 8'hC0};
        n_chk++;
        if (obs() !== e17) begin
            n_fail++;
            $display("FAIL stall_handover: got %h expected %h", obs(), e17);
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall_idle: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
    endtask

    task automatic test_solo_regrant();
        cyc();
        set_din(0, 8'hD0);
        bus.req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            cyc();
            set_din(0, 8'(8'hD0 + k));
            exp_q.push_back(8'(8'hD0 + k));
            #1;
            e17 = {4'b0001, 4'b0001, 1'b1, 8'(8'hD0 + k)};
            n_chk++;
            if (obs() !== e17) begin
                n_fail++;
                $display("FAIL solo_beat[%0d]: got %h expected %h", k, obs(), e17);
            end
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL solo_idle: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
    endtask

    task automatic test_async_reset();
        cyc();
        set_din(3, 8'hE0);
        bus.req = 4'b1000;
        cyc();
        exp_q.push_back(8'hE0);
        #1;
        n_chk++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL ar_grant: gnt=%b expected %b", bus.gnt, 4'b1000);
        end
        cyc();
        set_din(3, 8'hE1);
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if (obs() !== 17'h0) begin
            n_fail++;
            $display("FAIL ar_immediate: got %h expected %h", obs(), 17'h0);
        end
        cyc();
        cyc();
        rst = 1'b1;
        set_din(3, 8'hE2);
        #1;
        n_chk++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL ar_post_latency: gnt=%b expected %b", bus.gnt, 4'b0000);
        end
        cyc();
        exp_q.push_back(8'hE2);
        #1;
        e17 = {4'b1000, 4'b1000, 1'b1, 8'hE2};
        n_chk++;
        if (obs() !== e17) begin
            n_fail++;
            $display("FAIL ar_regrant: got %h expected %h", obs(), e17);
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_solo_regrant();
        test_async_reset();
        cyc();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d writes missing, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
